modexp_ctrl: RTL and testbench

- Sequencer for RSA modular exponentiation, result = base^exp mod n, using left-to-right binary square-and-multiply.
- Owns no arithmetic. It drives one external Montgomery multiplier (mont(a,b) = a*b*R^-1 mod n, R = 2^WIDTH) through a start/finish handshake.
- It converts operands into the Montgomery domain, schedules the square and multiply steps, and converts the result back.
- Sits between the RSA top-level command interface and the modular-multiplier datapath.

---
 rtl/rsa_pkg.sv | 23 ++
 rtl/modexp_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_modexp_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation control path:
// sequencer state encoding and the default operand width.
package rsa_pkg;

    localparam int WIDTH_DEF = 2048;
    localparam int ST_W      = 3;

    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_CV_B   = 3'd1;
    localparam logic [ST_W-1:0] ST_CV_1   = 3'd2;
    localparam logic [ST_W-1:0] ST_SCAN   = 3'd3;
    localparam logic [ST_W-1:0] ST_SQR    = 3'd4;
    localparam logic [ST_W-1:0] ST_MUL    = 3'd5;
    localparam logic [ST_W-1:0] ST_CV_OUT = 3'd6;
    localparam logic [ST_W-1:0] ST_DONE   = 3'd7;

    // True for the states that own an outstanding Montgomery multiply.
    function automatic logic is_mm_state(input logic [ST_W-1:0] s);
        return (s == ST_CV_B) || (s == ST_CV_1) || (s == ST_SQR) ||
               (s == ST_MUL)  || (s == ST_CV_OUT);
    endfunction

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for base^exp mod n.
// Drives an external Montgomery multiplier through mm_start/mm_finish;
// operands enter the Montgomery domain via mont(x, R^2) and the result
// leaves it via mont(acc, 1).
module modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int EXP_W = WIDTH,
    parameter int CNT_W = $clog2(EXP_W)
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exp,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] r2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] mm_x,
    output logic [WIDTH-1:0] mm_y,
    output logic [WIDTH-1:0] mm_n,
    output logic             mm_start,
    input  logic             mm_finish,
    input  logic [WIDTH-1:0] mm_result
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [CNT_W-1:0] IDX_TOP  = CNT_W'(EXP_W - 1);
    localparam logic [CNT_W-1:0] IDX_STEP = CNT_W'(1);

    logic [ST_W-1:0]  state_reg,  state_next;
    logic [WIDTH-1:0] bm_reg,     bm_next;
    logic [WIDTH-1:0] acc_reg,    acc_next;
    logic [EXP_W-1:0] e_reg,      e_next;
    logic [CNT_W-1:0] idx_reg,    idx_next;
    logic [WIDTH-1:0] n_reg,      n_next;
    logic [WIDTH-1:0] r2_reg,     r2_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             err_reg,    err_next;
    logic             pend_reg;
    logic             mm_start_reg;
    logic [WIDTH-1:0] mm_x_reg;
    logic [WIDTH-1:0] mm_y_reg;

    // Launch request for the multiply owned by the next state, with its operands.
    logic             launch;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic             fin;

    // A finish only counts while a multiply is actually outstanding.
    assign fin = pend_reg && mm_finish && is_mm_state(state_reg);

    // Next-state, datapath-register and multiply-launch decisions.
    always_comb begin
        state_next  = state_reg;
        bm_next     = bm_reg;
        acc_next    = acc_reg;
        e_next      = e_reg;
        idx_next    = idx_reg;
        n_next      = n_reg;
        r2_next     = r2_reg;
        result_next = result_reg;
        err_next    = err_reg;
        launch      = 1'b0;
        op_x        = '0;
        op_y        = '0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    e_next      = exp;
                    n_next      = n;
                    r2_next     = r2;
                    result_next = '0;
                    err_next    = 1'b0;
                    if (!n[0] || (n <= ONE)) begin
                        err_next   = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_CV_B;
                        launch     = 1'b1;
                        op_x       = base;
                        op_y       = r2;
                    end
                end
            end
            ST_CV_B: begin
                if (fin) begin
                    bm_next    = mm_result;
                    state_next = ST_CV_1;
                    launch     = 1'b1;
                    op_x       = ONE;
                    op_y       = r2_reg;
                end
            end
            ST_CV_1: begin
                if (fin) begin
                    acc_next   = mm_result;
                    idx_next   = IDX_TOP;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (e_reg[idx_reg]) begin
                    state_next = ST_SQR;
                    launch     = 1'b1;
                    op_x       = acc_reg;
                    op_y       = acc_reg;
                end else if (idx_reg == '0) begin
                    state_next = ST_CV_OUT;
                    launch     = 1'b1;
                    op_x       = acc_reg;
                    op_y       = ONE;
                end else begin
                    idx_next = idx_reg - IDX_STEP;
                end
            end
            ST_SQR: begin
                if (fin) begin
                    acc_next = mm_result;
                    launch   = 1'b1;
                    op_x     = mm_result;
                    if (e_reg[idx_reg]) begin
                        state_next = ST_MUL;
                        op_y       = bm_reg;
                    end else if (idx_reg == '0) begin
                        state_next = ST_CV_OUT;
                        op_y       = ONE;
                    end else begin
                        idx_next   = idx_reg - IDX_STEP;
                        state_next = ST_SQR;
                        op_y       = mm_result;
                    end
                end
            end
            ST_MUL: begin
                if (fin) begin
                    acc_next = mm_result;
                    launch   = 1'b1;
                    op_x     = mm_result;
                    if (idx_reg == '0) begin
                        state_next = ST_CV_OUT;
                        op_y       = ONE;
                    end else begin
                        idx_next   = idx_reg - IDX_STEP;
                        state_next = ST_SQR;
                        op_y       = mm_result;
                    end
                end
            end
            ST_CV_OUT: begin
                if (fin) begin
                    result_next = mm_result;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run in flight.
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            state_reg  <= ST_IDLE;
            bm_reg     <= '0;
            acc_reg    <= '0;
            e_reg      <= '0;
            idx_reg    <= '0;
            n_reg      <= '0;
            r2_reg     <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            bm_reg     <= bm_next;
            acc_reg    <= acc_next;
            e_reg      <= e_next;
            idx_reg    <= idx_next;
            n_reg      <= n_next;
            r2_reg     <= r2_next;
            result_reg <= result_next;
            err_reg    <= err_next;
        end
    end

    // Multiplier handshake: one-cycle start pulse, operands held until the
    // next launch, pend tracks the single outstanding multiply.
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            mm_start_reg <= 1'b0;
            pend_reg     <= 1'b0;
            mm_x_reg     <= '0;
            mm_y_reg     <= '0;
        end else begin
            mm_start_reg <= launch;
            pend_reg     <= launch || (pend_reg && !fin);
            if (launch) begin
                mm_x_reg <= op_x;
                mm_y_reg <= op_y;
            end
        end
    end

    assign busy     = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done     = (state_reg == ST_DONE);
    assign err      = err_reg;
    assign result   = result_reg;
    assign mm_x     = mm_x_reg;
    assign mm_y     = mm_y_reg;
    assign mm_n     = n_reg;
    assign mm_start = mm_start_reg;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Testbench for modexp_ctrl at WIDTH=16 with a behavioural 5-cycle
// Montgomery multiplier and a plain-arithmetic modular power reference.
module tb_modexp_ctrl;

    localparam int W   = 16;
    localparam int EW  = 16;
    localparam int LAT = 5;

    logic          clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  base = '0;
    logic [EW-1:0] exp_in = '0;
    logic [W-1:0]  n = '0;
    logic [W-1:0]  r2 = '0;
    logic          busy, done, err;
    logic [W-1:0]  result, mm_x, mm_y, mm_n;
    logic          mm_start;
    logic          mm_finish = 1'b0;
    logic [W-1:0]  mm_result = '0;

    modexp_ctrl #(.WIDTH(W), .EXP_W(EW)) dut (
        .clk(clk), .sys_rst(sys_rst), .start(start), .base(base), .exp(exp_in),
        .n(n), .r2(r2), .busy(busy), .done(done), .err(err), .result(result),
        .mm_x(mm_x), .mm_y(mm_y), .mm_n(mm_n), .mm_start(mm_start),
        .mm_finish(mm_finish), .mm_result(mm_result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Responder / monitor state (written only by the responder process).
    int cyc = 0, start_cnt = 0, fin_cnt = 0, done_cnt = 0, stab_bad = 0;
    int last_fin = 0, cd = 0, spur_cd = 0;
    int gap_q[$];
    bit stale = 1'b0;
    logic [W-1:0] px = '0, py = '0, pval = '0;
    // Written only by the main process.
    logic [W-1:0] cur_n = '0;
    bit inject_spur = 1'b0;
    int spur_at = -1;

    function automatic logic [63:0] mont(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] m);
        logic [63:0] t;
        t = a * b;
        for (int i = 0; i < W; i++) begin
            if (t[0]) t = t + m;
            t = t >> 1;
        end
        if (t >= m) t = t - m;
        return t;
    endfunction

    function automatic logic [63:0] ref_pow(input logic [63:0] b, input logic [63:0] e,
                                            input logic [63:0] m);
        logic [63:0] r, x, k;
        r = 64'd1 % m;
        x = b % m;
        k = e;
        while (k != 0) begin
            if (k[0]) r = (r * x) % m;
            x = (x * x) % m;
            k = k >> 1;
        end
        return r;
    endfunction

    function automatic int msb_pos(input logic [EW-1:0] e);
        for (int i = EW - 1; i >= 0; i--) if (e[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
        end
    endtask

    // Behavioural multiplier: LAT cycles after mm_start, one-cycle finish.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            mm_finish = 1'b0;
            mm_result = '0;
            if (done) done_cnt++;
            if (!sys_rst) stale = 1'b1;
            if (mm_start) begin
                start_cnt++;
                gap_q.push_back(cyc - last_fin);
                px    = mm_x;
                py    = mm_y;
                pval  = W'(mont(64'(px), 64'(py), 64'(cur_n)));
                cd    = LAT;
                stale = 1'b0;
            end else if (cd > 0) begin
                if (!stale && (mm_x !== px || mm_y !== py)) stab_bad++;
                cd--;
                if (cd == 0) begin
                    mm_finish = 1'b1;
                    mm_result = pval;
                    fin_cnt++;
                    last_fin = cyc;
                    if (inject_spur && fin_cnt == spur_at) spur_cd = 3;
                end
            end else if (spur_cd > 0) begin
                spur_cd--;
                if (spur_cd == 0) begin
                    mm_finish = 1'b1;
                    mm_result = W'($urandom);
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] b, input logic [EW-1:0] e,
                          input logic [W-1:0] m, input bit hold, input string tag);
        bit exp_err;
        logic [63:0] exp_res, r2v;
        int exp_starts, exp_gap, s0, sb, lat, msb;
        exp_err = (m[0] == 1'b0) || (m <= 1);
        r2v     = exp_err ? 64'd0 : ((64'd1 << (2 * W)) % 64'(m));
        exp_res = exp_err ? 64'd0 : ref_pow(64'(b), 64'(e), 64'(m));
        msb     = msb_pos(e);
        exp_starts = exp_err ? 0 : (3 + (msb + 1) + $countones(e));
        exp_gap    = (msb < 0) ? EW + 1 : (EW - 1 - msb) + 2;
        s0 = start_cnt;
        sb = stab_bad;
        @(negedge clk);
        cur_n = m; base = b; exp_in = e; n = m; r2 = W'(r2v); start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        lat = 1;
        chk({tag, "_busy"}, 64'(busy), 64'(!exp_err));
        while (!done && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        chk({tag, "_result"}, 64'(result), exp_res);
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        chk({tag, "_mm_starts"}, 64'(start_cnt - s0), 64'(exp_starts));
        if (exp_err) begin
            chk({tag, "_err_latency_le2"}, 64'(lat <= 2), 64'd1);
        end else begin
            chk({tag, "_scan_gap"}, 64'(gap_q[s0 + 2]), 64'(exp_gap));
            chk({tag, "_operand_stable"}, 64'(stab_bad - sb), 64'd0);
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_idle_after"}, 64'(busy), 64'd0);
        chk({tag, "_result_held"}, 64'(result), exp_res);
        $display("op %s base=%0d exp=%0d n=%0d -> result=%0d err=%0d starts=%0d",
                 tag, b, e, m, result, err, start_cnt - s0);
    endtask

    initial begin
        int s0, d0, guard;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_mm_start", 64'(mm_start), 64'd0);
        chk("rst_mm_xy", 64'({mm_x, mm_y}), 64'd0);
        sys_rst = 1'b1;
        @(negedge clk);

        run_op(16'd4, 16'd13, 16'd11, 1'b0, "pow4_13");
        run_op(16'd7, 16'd0,  16'd11, 1'b0, "exp0");
        run_op(16'd5, 16'd7,  16'd10, 1'b0, "n_even");
        run_op(16'd5, 16'd7,  16'd1,  1'b0, "n_one");
        run_op(16'd2, 16'hFFFF, 16'd11, 1'b0, "exp_ones");

        // Start held through the whole run and a stray finish during SCAN.
        inject_spur = 1'b1;
        spur_at     = fin_cnt + 2;
        run_op(16'd4, 16'd13, 16'd11, 1'b1, "hold_spur");
        inject_spur = 1'b0;

        // Reset while a square is outstanding.
        s0 = start_cnt;
        d0 = done_cnt;
        @(negedge clk);
        cur_n = 16'd11; base = 16'd4; exp_in = 16'd13; n = 16'd11;
        r2 = W'((64'd1 << (2 * W)) % 64'd11); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (start_cnt < s0 + 5 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_reached_sqr", 64'(start_cnt >= s0 + 5), 64'd1);
        @(negedge clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_mm_start", 64'(mm_start), 64'd0);
        sys_rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);
        run_op(16'd3, 16'd5, 16'd11, 1'b0, "after_abort");

        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] rn, rb;
            logic [EW-1:0] re;
            rn = W'($urandom_range(3, 65535)) | 16'd1;
            rb = W'($urandom);
            re = EW'($urandom);
            run_op(rb, re, rn, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
